pio_access_arbiter: RTL

Round-robin arbiter that shares one Avalon-MM PIO register slave (2-bit address, chipselect, write_n, 32-bit writedata/readdata, zero wait states) between several on-fabric requesters. Each requester issues single read or write commands through a req/ack handshake. The arbiter serialises the commands into single-cycle slave accesses and returns read data. It sits between FPGA-side game logic and the LED/status PIO, so software-owned and hardware-owned writers never collide on the bus.

---
 rtl/pio_access_arbiter_pkg.sv | 14 +
 rtl/pio_access_arbiter_if.sv | 38 +++
 rtl/pio_access_arbiter_rr_picker.sv | 36 +++
 rtl/pio_access_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/pio_access_arbiter_pkg.sv
// Shared types and constants for the PIO access arbiter.
// Imported by the interface, the picker and the top level.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int BUS_W    = 32;
    localparam int DATA_REG = 0;

endpackage

// File: rtl/pio_access_arbiter_if.sv
// Requester command bundle plus the Avalon-MM PIO slave bus.
// The slave modport is the arbiter's view; master is the fabric side.
interface pio_access_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    import pio_arb_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rdata;
    logic                    busy;

    logic [ADDR_W-1:0]       avm_address;
    logic                    avm_chipselect;
    logic                    avm_write_n;
    logic [BUS_W-1:0]        avm_writedata;
    logic [BUS_W-1:0]        avm_readdata;

    modport slave (
        input  req, we, addr, wdata, avm_readdata,
        output ack, rdata, busy,
        output avm_address, avm_chipselect,
        output avm_write_n, avm_writedata
    );

    modport master (
        output req, we, addr, wdata, avm_readdata,
        input  ack, rdata, busy,
        input  avm_address, avm_chipselect,
        input  avm_write_n, avm_writedata
    );

endinterface

// File: rtl/pio_access_arbiter_rr_picker.sv
// Combinational round-robin picker: search starts at ptr+1.
// Double-width rotate then lowest-set-bit priority encode.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W:0]   w_start;
    logic [N_REQ-1:0] w_rot;
    int               w_sum;

    always_comb begin
        w_start = {1'b0, i_ptr} + 1'b1;
        w_rot   = N_REQ'({i_req, i_req} >> w_start);
        o_idx   = '0;
        w_sum   = 0;
        // Walk downwards so the lowest set bit is the last one written
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = int'(w_start) + k;
                if (w_sum >= N_REQ)
                    w_sum = w_sum - N_REQ;
                o_idx = IDX_W'(w_sum);
            end
        end
        o_grant = '0;
        if (|w_rot)
            o_grant = N_REQ'(1) << o_idx;
    end

endmodule

// File: rtl/pio_access_arbiter.sv
// Round-robin arbiter serialising requester commands onto one
// zero-wait-state Avalon-MM PIO slave, returning read data.
module pio_access_arbiter
    import pio_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_access_arbiter_if.slave  pio
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic [N_REQ-1:0]    r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic [N_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic                w_unused;

    assign w_any    = |pio.req;
    assign w_unused = &{1'b0, pio.avm_readdata};

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (pio.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= IDX_W'(N_REQ - 1);
            r_idx   <= '0;
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            // Command is frozen here; later input changes are ignored
            if (r_state == IDLE && w_any) begin
                r_idx   <= w_idx;
                r_grant <= w_grant;
                r_we    <= pio.we[w_idx];
                r_addr  <= pio.addr[w_idx*ADDR_W +: ADDR_W];
                r_wdata <= pio.wdata[w_idx*DATA_W +: DATA_W];
            end
            if (r_state == ISSUE) begin
                r_ptr <= r_idx;
                if (!r_we)
                    r_rdata <= pio.avm_readdata[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        w_next             = r_state;
        pio.ack            = '0;
        pio.avm_chipselect = 1'b0;
        pio.avm_write_n    = 1'b1;
        pio.avm_address    = ADDR_W'(DATA_REG);
        pio.avm_writedata  = '0;
        unique case (r_state)
            IDLE: begin
                if (w_any)
                    w_next = ISSUE;
            end
            ISSUE: begin
                w_next             = ACK;
                pio.avm_chipselect = 1'b1;
                pio.avm_write_n    = ~r_we;
                pio.avm_address    = r_addr;
                pio.avm_writedata  = BUS_W'(r_wdata);
            end
            ACK: begin
                w_next  = IDLE;
                pio.ack = r_grant;
            end
            default: w_next = IDLE;
        endcase
    end

    assign pio.busy  = (r_state != IDLE);
    assign pio.rdata = r_rdata;

endmodule
